// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: hazard, branch and memory-wait arbitration plus dmem watchdog.
// Optional STALL_STATS_EN adds saturating stall/flush statistics counters.
module pipeline_stall_controller #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             idex_memread,
  input  logic [4:0]       idex_dest,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             branch_taken,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_freeze,
  output logic             mem_timeout
`ifdef STALL_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
`endif
);

  // state   | meaning
  // RUN     | normal issue, hazards arbitrated each cycle
  // DISCARD | wrong-path fetch still in flight, drop it on arrival
  // HALTED  | dmem never answered, pipeline frozen until reset
  typedef enum logic [1:0] {RUN, DISCARD, HALTED} state_t;

  localparam int WD_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (MEM_TIMEOUT > 0) ? WD_W'(MEM_TIMEOUT - 1) : '0;

  state_t          state, next_state;
  logic [WD_W-1:0] wd_cnt;
  logic            load_use;
  logic            wd_expire;

  assign load_use = idex_memread && (idex_dest != 5'd0) &&
                    ((idex_dest == ifid_rs) || (idex_dest == ifid_rt));

  assign wd_expire = (MEM_TIMEOUT != 0) && dmem_busy && (wd_cnt == WD_LAST);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= RUN;
      wd_cnt <= '0;
    end else begin
      state <= next_state;
      if (!dmem_busy)
        wd_cnt <= '0;
      else if (wd_cnt != '1)
        wd_cnt <= wd_cnt + 1'b1;
    end
  end

  always_comb begin
    next_state  = state;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    mem_timeout = 1'b0;
    if (!resetn) begin
      pipe_freeze = 1'b1;
    end else begin
      case (state)
        HALTED: begin
          pipe_freeze = 1'b1;
          mem_timeout = 1'b1;
        end
        default: begin
          if (dmem_busy) begin
            pipe_freeze = 1'b1;
          end else if (branch_taken) begin
            pc_write    = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            next_state  = imem_busy ? DISCARD : RUN;
          end else if (state == DISCARD) begin
            // ID already holds a NOP, so a load-use match here is meaningless
            ifid_flush = 1'b1;
            if (!imem_busy)
              next_state = RUN;
          end else if (load_use) begin
            idex_bubble = 1'b1;
          end else if (imem_busy) begin
            ifid_flush = 1'b1;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
          end
        end
      endcase
      if (wd_expire)
        next_state = HALTED;
    end
  end

`ifdef STALL_STATS_EN
  logic lu_resp;
  logic br_resp;

  assign lu_resp = (state == RUN) && !dmem_busy && !branch_taken && load_use;
  assign br_resp = (state != HALTED) && !dmem_busy && branch_taken;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (lu_resp && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
      if (br_resp && (flush_events != '1))
        flush_events <= flush_events + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller: spec-level model compared every cycle plus literal pins.
module tb_pipeline_stall_controller;
  localparam int MT = 11;
  localparam int CW = 16;

  logic       clock = 1'b0;
  logic       resetn;
  logic       idex_memread;
  logic [4:0] idex_dest, ifid_rs, ifid_rt;
  logic       branch_taken, imem_busy, dmem_busy;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, mem_timeout;
`ifdef STALL_STATS_EN
  logic [CW-1:0] stall_cycles, flush_events;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // model: halted / discarding flags, consecutive busy count, statistics
  bit  m_halted  = 0;
  bit  m_discard = 0;
  int  m_busy_run = 0;
  int  m_stalls = 0;
  int  m_flushes = 0;

  bit         pin_en = 0;
  logic [5:0] pin_val = '0;
  string      pin_name = "";
  logic [5:0] act_v, exp_v;

  pipeline_stall_controller #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clock(clock), .resetn(resetn),
    .idex_memread(idex_memread), .idex_dest(idex_dest),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .branch_taken(branch_taken), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze), .mem_timeout(mem_timeout)
`ifdef STALL_STATS_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  always #5 clock = ~clock;

  function automatic bit hazard();
    return idex_memread && (idex_dest != 0) && (idex_dest == ifid_rs || idex_dest == ifid_rt);
  endfunction

  // {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, mem_timeout}
  function automatic logic [5:0] expected();
    if (!resetn)            return 6'b000010;
    if (m_halted)           return 6'b000011;
    if (dmem_busy)          return 6'b000010;
    if (branch_taken)       return 6'b101100;
    if (m_discard)          return 6'b001000;
    if (hazard())           return 6'b000100;
    if (imem_busy)          return 6'b001000;
    return 6'b110000;
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_halted = 0; m_discard = 0; m_busy_run = 0; m_stalls = 0; m_flushes = 0;
    end else if (!m_halted) begin
      if (!dmem_busy && branch_taken) m_flushes++;
      if (!dmem_busy && !branch_taken && !m_discard && hazard()) m_stalls++;
      m_busy_run = dmem_busy ? m_busy_run + 1 : 0;
      if (MT != 0 && m_busy_run >= MT)
        m_halted = 1;
      else if (!dmem_busy) begin
        if (branch_taken)    m_discard = imem_busy;
        else if (!imem_busy) m_discard = 0;
      end
    end
  end

  always @(negedge clock) begin
    act_v = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, mem_timeout};
    exp_v = expected();
    n_tests++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL model_outputs t=%0t got %b expected %b", $time, act_v, exp_v);
    end
`ifdef STALL_STATS_EN
    n_tests++;
    if (stall_cycles !== CW'(m_stalls) || flush_events !== CW'(m_flushes)) begin
      n_fail++;
      $display("FAIL stats t=%0t got stall=%0d flush=%0d expected stall=%0d flush=%0d",
               $time, stall_cycles, flush_events, m_stalls, m_flushes);
    end
`endif
    if (pin_en) begin
      n_tests++;
      if (act_v !== pin_val) begin
        n_fail++;
        $display("FAIL %s t=%0t got %b expected %b", pin_name, $time, act_v, pin_val);
      end
    end
  end

  task automatic step(input string nm, input logic rn, input logic mr, input logic [4:0] d,
                      input logic [4:0] rs, input logic [4:0] rt, input logic br,
                      input logic ib, input logic db, input logic [5:0] pin);
    resetn = rn; idex_memread = mr; idex_dest = d; ifid_rs = rs; ifid_rt = rt;
    branch_taken = br; imem_busy = ib; dmem_busy = db;
    pin_name = nm; pin_val = pin; pin_en = 1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    resetn = 0; idex_memread = 0; idex_dest = 0; ifid_rs = 0; ifid_rt = 0;
    branch_taken = 0; imem_busy = 0; dmem_busy = 0;
    @(posedge clock); #1;
    step("reset_busy_inputs", 0, 1, 8, 8, 0, 1, 0, 1, 6'b000010);
    step("reset_hold",        0, 0, 0, 0, 0, 0, 0, 0, 6'b000010);
    step("run",               1, 0, 0, 0, 0, 0, 0, 0, 6'b110000);
    step("lu_rs",             1, 1, 8, 8, 0, 0, 0, 0, 6'b000100);
    step("lu_after",          1, 0, 8, 8, 0, 0, 0, 0, 6'b110000);
    step("lu_dest0",          1, 1, 0, 3, 0, 0, 0, 0, 6'b110000);
    step("lu_rt",             1, 1, 5, 1, 5, 0, 0, 0, 6'b000100);
    step("lu_nomatch",        1, 1, 5, 1, 2, 0, 0, 0, 6'b110000);
    step("br_imem_busy",      1, 0, 0, 0, 0, 1, 1, 0, 6'b101100);
    step("discard_1",         1, 0, 0, 0, 0, 0, 1, 0, 6'b001000);
    step("discard_2",         1, 0, 0, 0, 0, 0, 1, 0, 6'b001000);
    step("discard_drop",      1, 0, 0, 0, 0, 0, 0, 0, 6'b001000);
    step("after_discard",     1, 0, 0, 0, 0, 0, 0, 0, 6'b110000);
    step("br_and_lu",         1, 1, 3, 3, 0, 1, 0, 0, 6'b101100);
    step("br_lu_next",        1, 0, 3, 3, 0, 0, 0, 0, 6'b110000);
    for (int i = 0; i < 10; i++)
      step("dmem_busy_lu",    1, 1, 8, 8, 0, 0, 0, 1, 6'b000010);
    step("lu_after_dmem",     1, 1, 8, 8, 0, 0, 0, 0, 6'b000100);
    step("imem_busy_run",     1, 0, 0, 0, 0, 0, 1, 0, 6'b001000);
    step("br_to_discard",     1, 0, 0, 0, 0, 1, 1, 0, 6'b101100);
    step("discard_ignores_lu",1, 1, 7, 0, 7, 0, 1, 0, 6'b001000);
    step("discard_dmem",      1, 1, 7, 0, 7, 0, 1, 1, 6'b000010);
    step("discard_exit_lu",   1, 1, 7, 0, 7, 0, 0, 0, 6'b001000);
    step("run_lu_again",      1, 1, 7, 0, 7, 0, 0, 0, 6'b000100);
    step("br_to_discard2",    1, 0, 0, 0, 0, 1, 1, 0, 6'b101100);
    step("reset_mid_discard", 0, 1, 7, 7, 0, 0, 1, 0, 6'b000010);
    step("run_after_reset",   1, 1, 7, 7, 0, 0, 1, 0, 6'b000100);
    step("idle",              1, 0, 0, 0, 0, 0, 0, 0, 6'b110000);
    for (int i = 0; i < MT; i++)
      step("wd_busy",         1, 0, 0, 0, 0, 0, 0, 1, 6'b000010);
    step("wd_halted",         1, 0, 0, 0, 0, 0, 0, 0, 6'b000011);
    step("halted_ignores_br", 1, 1, 3, 3, 0, 1, 1, 0, 6'b000011);
    step("halted_reset",      0, 0, 0, 0, 0, 0, 0, 0, 6'b000010);
    step("post_halt_run",     1, 0, 0, 0, 0, 0, 0, 0, 6'b110000);
    pin_en = 0;
    @(negedge clock); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central stall/flush sequencer for the 5-stage pipeline. Each cycle it combines load-use hazard detection (ID/EX load vs. IF/ID sources), taken-branch flush from EX, instruction-fetch wait, and data-memory wait into one consistent set of register enables for PC, IF/ID, ID/EX (bubble mux) and the back-end stage registers. A small FSM discards a wrong-path fetch still in flight when a branch resolves. A watchdog halts the pipeline if data memory never answers.

## Interface
- MEM_TIMEOUT, 255: consecutive dmem_busy cycles before halting; 0 disables the watchdog.
- CNT_W, 16: width of statistics counters (only with STALL_STATS_EN).
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- idex_memread  in  1  instruction in ID/EX is a load
- idex_dest  in  5  destination register of ID/EX instruction
- ifid_rs, ifid_rt  in  5 each  source registers of IF/ID instruction
- branch_taken  in  1  EX resolved a taken branch/jump this cycle
- imem_busy  in  1  instruction fetch not complete this cycle
- dmem_busy  in  1  data access in MEM not complete this cycle
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  load NOP into IF/ID (overrides ifid_write)
- idex_bubble  out  1  select zeroed control into ID/EX
- pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
- mem_timeout  out  1  sticky watchdog flag
- stall_cycles, flush_events  out  CNT_W each  (STALL_STATS_EN only)

## Operation
- Outputs are combinational from state and inputs; state, watchdog and counters are registered.
- load_use = idex_memread & (idex_dest != 0) & (idex_dest == ifid_rs | idex_dest == ifid_rt).
- States: RUN, DISCARD, HALTED. Priority per cycle in RUN, first match wins:
  - dmem_busy: pipe_freeze=1, pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=0; state unchanged.
  - branch_taken: pc_write=1, ifid_flush=1, idex_bubble=1; next DISCARD if imem_busy else RUN.
  - load_use: pc_write=0, ifid_write=0, idex_bubble=1 (imem_busy irrelevant).
  - imem_busy: pc_write=0, ifid_flush=1.
  - otherwise: pc_write=1, ifid_write=1, others 0.
- DISCARD (wrong-path fetch in flight): dmem_busy and branch_taken handled as in RUN; load_use ignored (ID holds NOP); otherwise pc_write=0, ifid_flush=1; next RUN when imem_busy=0 (the returning instruction is dropped that cycle), else stay.
- HALTED: pipe_freeze=1, pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=0, mem_timeout=1; exits only via reset.
- Watchdog: counter increments each dmem_busy=1 cycle, clears on dmem_busy=0; on the edge closing the MEM_TIMEOUT-th consecutive busy cycle, go HALTED from any state.

## Timing
- Zero-cycle decision latency: hazards act in the cycle they are presented.
- Load-use stall lasts exactly one cycle per occurrence (bubble clears idex_memread).
- Branch with imem_busy=0: one flush cycle, fetch of target next cycle. With imem_busy high for N cycles: N+1 cycles with ifid_flush=1.
- During resetn low: state RUN, watchdog 0, counters 0, mem_timeout=0; pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=0, pipe_freeze=1. Reset mid-DISCARD or mid-HALTED returns to RUN.
- Simultaneous branch_taken + load_use: branch wins (ID instruction is wrong-path).

## Configuration
- STALL_STATS_EN defined: stall_cycles increments on every cycle outputting the load_use response; flush_events increments on every branch_taken response; both saturate at all-ones, reset to 0, hold while pipe_freeze=1.
- Undefined: both ports and counters absent; all other behaviour identical.

## Test plan
- idex_memread=1, idex_dest=8, ifid_rs=8 -> one cycle pc_write=0, ifid_write=0, idex_bubble=1; next cycle (memread=0) pc_write=1, ifid_write=1.
- idex_memread=1, idex_dest=0, ifid_rt=0 -> no stall, pc_write=1.
- branch_taken=1 with imem_busy=1 for 3 cycles -> 4 cycles ifid_flush=1, pc_write=1 only first cycle, state back to RUN after 4th.
- branch_taken=1 and load_use same cycle -> pc_write=1, ifid_flush=1, idex_bubble=1; stall_cycles unchanged, flush_events +1.
- dmem_busy=1 for 10 cycles during load_use -> pipe_freeze=1, idex_bubble=0 for 10 cycles, then one load-use stall cycle.
- MEM_TIMEOUT=4, dmem_busy held -> mem_timeout=1 after 4th busy cycle edge, outputs frozen; resetn pulse low clears it.
